// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared definitions for the lab RAM front end: controller state encoding,
// default RAM geometry, and the RAM read latency (also used by the RAM wrapper).
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  // Address register plus output register inside the RAM macro.
  localparam int RAM_RD_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WAIT,
    CAPTURE
  } state_t;

endpackage

// File: rtl/ram_access_ctrl_switch_debounce.sv
// switch_debounce
// Synchronizes a raw switch, filters it with a stability counter and emits a
// one-cycle pulse on each accepted 0->1 change of the filtered level.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   raw    in   asynchronous switch input
//   rise   out  one-cycle pulse on an accepted rising edge
module switch_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_p0, sync_p1;
  logic             prime_p0, prime_p1;
  logic             level;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      prime_p0 <= 1'b0;
      prime_p1 <= 1'b0;
      level    <= 1'b0;
      armed    <= 1'b0;
      cnt      <= '0;
      rise     <= 1'b0;
    end else begin
      // Stage p0 -> p1: metastability filter
      sync_p0  <= raw;
      sync_p1  <= sync_p0;
      prime_p0 <= 1'b1;
      prime_p1 <= prime_p0;
      rise     <= 1'b0;
      // A switch already high when reset releases must be seen low once
      // before its edge counts; prime_p1 marks sync_p1 as a real sample.
      if (prime_p1 && !sync_p1 && !level)
        armed <= 1'b1;
      // Stage p1 -> level: accept a new level only after it holds steadily
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_p1;
        rise  <= sync_p1 & armed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Front end for the single-port lab RAM. Turns the write switch into one
// clean write request, runs a periodic read scan of all addresses, and
// arbitrates both so the RAM sees one access per cycle. The last scan read
// is registered for the display stage.
// Ports:
//   CLOCK_50     in   clock
//   rst_n        in   asynchronous active-low reset
//   sw_wr_req    in   raw write switch
//   sw_wr_addr   in   raw write address switches
//   sw_wr_data   in   raw write data switches
//   ram_address  out  RAM address
//   ram_data     out  RAM write data (zero outside a write)
//   ram_wren     out  RAM write enable
//   ram_q        in   RAM read data
//   disp_addr    out  address of the last completed scan read
//   disp_data    out  data of the last completed scan read
//   disp_valid   out  one-cycle pulse when disp_addr/disp_data update
//   wr_done      out  one-cycle pulse when a write is issued
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TICK_DIV  = 25_000_000,
  parameter int DB_CYCLES = 1_000_000,
  parameter int RD_LAT    = RAM_RD_LAT
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              sw_wr_req,
  input  logic [ADDR_W-1:0] sw_wr_addr,
  input  logic [DATA_W-1:0] sw_wr_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              wr_done
);

  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam int WAIT_W = $clog2(RD_LAT + 1);
  // WAIT lasts RD_LAT-1 cycles, so its last count is RD_LAT-2.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 2);

  state_t              state;
  logic                wr_rise;
  logic                wr_pend, rd_pend;
  logic [ADDR_W-1:0]   addr_sync_p0, addr_sync_p1;
  logic [DATA_W-1:0]   data_sync_p0, data_sync_p1;
  logic [ADDR_W-1:0]   wr_addr, rd_addr, scan_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick_wrap;
  logic [WAIT_W-1:0]   wait_cnt;

  switch_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_wr_db (
    .clk  (CLOCK_50),
    .rst_n(rst_n),
    .raw  (sw_wr_req),
    .rise (wr_rise)
  );

  // Stage p0 -> p1: address/data switch synchronizers, then the write latch
  always_ff @(posedge CLOCK_50) begin
    addr_sync_p0 <= sw_wr_addr;
    addr_sync_p1 <= addr_sync_p0;
    data_sync_p0 <= sw_wr_data;
    data_sync_p1 <= data_sync_p0;
    if (wr_rise) begin
      wr_addr <= addr_sync_p1;
      wr_data <= data_sync_p1;
    end
  end

  assign tick_wrap = (tick_cnt == TICK_LAST);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      scan_addr <= '0;
    end else if (tick_wrap) begin
      tick_cnt  <= '0;
      scan_addr <= scan_addr + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_pend     <= 1'b0;
      rd_pend     <= 1'b0;
      rd_addr     <= '0;
      wait_cnt    <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      wr_done     <= 1'b0;
      disp_addr   <= '0;
      disp_data   <= '0;
      disp_valid  <= 1'b0;
    end else begin
      ram_wren   <= 1'b0;
      ram_data   <= '0;
      wr_done    <= 1'b0;
      disp_valid <= 1'b0;
      // A new request landing on the clearing cycle wins, so none is lost;
      // repeated ticks simply merge into the one rd_pend.
      wr_pend <= wr_rise   | (wr_pend & (state != WRITE));
      rd_pend <= tick_wrap | (rd_pend & (state != READ));
      unique case (state)
        IDLE: begin
          // Outputs are registered, so they are loaded on entry to the
          // state in which the RAM must see them.
          if (wr_pend) begin
            state       <= WRITE;
            ram_address <= wr_addr;
            ram_data    <= wr_data;
            ram_wren    <= 1'b1;
            wr_done     <= 1'b1;
          end else if (rd_pend) begin
            state       <= READ;
            rd_addr     <= scan_addr;
            ram_address <= scan_addr;
          end
        end
        WRITE: state <= IDLE;
        READ: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // ram_address is left untouched until the data is captured.
          if (wait_cnt == WAIT_LAST) state <= CAPTURE;
          else wait_cnt <= wait_cnt + 1'b1;
        end
        CAPTURE: begin
          disp_addr  <= rd_addr;
          disp_data  <= ram_q;
          disp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl
// Directed bench for ram_access_ctrl with a two-cycle behavioural RAM.
// Timing targets are expressed in clock edges counted from reset release.
module tb_ram_access_ctrl;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 8;
  localparam int TICK_DIV  = 8;
  localparam int DB_CYCLES = 4;
  localparam int RD_LAT    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sw_wr_req;
  logic [ADDR_W-1:0] sw_wr_addr;
  logic [DATA_W-1:0] sw_wr_data;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              wr_done;

  always #5 clk = ~clk;

  ram_access_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICK_DIV(TICK_DIV),
    .DB_CYCLES(DB_CYCLES), .RD_LAT(RD_LAT)
  ) dut (
    .CLOCK_50   (clk),
    .rst_n      (rst_n),
    .sw_wr_req  (sw_wr_req),
    .sw_wr_addr (sw_wr_addr),
    .sw_wr_data (sw_wr_data),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .wr_done    (wr_done)
  );

  // Behavioural RAM: address register then output register.
  logic [DATA_W-1:0] mem [0:31] = '{default: '0};
  logic [ADDR_W-1:0] ram_addr_r = '0;
  logic [DATA_W-1:0] ram_q_r = '0;
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_addr_r <= ram_address;
    ram_q_r    <= mem[ram_addr_r];
  end
  assign ram_q = ram_q_r;

  // Expected RAM contents, written only by the stimulus below.
  logic [DATA_W-1:0] ref_mem [0:31] = '{default: '0};

  int cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Event recorder
  int                wr_cnt = 0, done_cnt = 0, wr_cyc = -1, disp_cyc = -1;
  int                seq_bad = 0, hist_bad = 0, data_bad = 0, zero_bad = 0;
  logic [ADDR_W-1:0] wr_a = '0, disp_a_last = '0, exp_next = 5'd1;
  logic [ADDR_W-1:0] a_d1 = '0, a_d2 = '0, a_d3 = '0;
  logic [DATA_W-1:0] wr_d = '0, d13 = 8'hEE, d14 = 8'hEE;
  logic              seen_wrap = 1'b0;

  always @(negedge clk) begin
    a_d1 <= ram_address;
    a_d2 <= a_d1;
    a_d3 <= a_d2;
    if (!rst_n) begin
      exp_next <= 5'd1;
    end else begin
      if (ram_wren) begin
        wr_cnt <= wr_cnt + 1;
        wr_a   <= ram_address;
        wr_d   <= ram_data;
        wr_cyc <= cyc;
      end
      if (wr_done) done_cnt <= done_cnt + 1;
      if (!ram_wren && ram_data != '0) zero_bad <= zero_bad + 1;
      if (disp_valid) begin
        disp_cyc    <= cyc;
        disp_a_last <= disp_addr;
        exp_next    <= disp_addr + 5'd1;
        if (disp_addr != exp_next) seq_bad <= seq_bad + 1;
        if (disp_data !== ref_mem[disp_addr]) data_bad <= data_bad + 1;
        // Address must sit on the RAM during READ and WAIT of this read.
        if (a_d2 != disp_addr || a_d3 != disp_addr) hist_bad <= hist_bad + 1;
        if (disp_addr == 5'h13) d13 <= disp_data;
        if (disp_addr == 5'h14) d14 <= disp_data;
        if (disp_addr == 5'h00) seen_wrap <= 1'b1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"},  32'(ram_address), 0);
    check({tag, "_data"},  32'(ram_data),    0);
    check({tag, "_wren"},  32'(ram_wren),    0);
    check({tag, "_done"},  32'(wr_done),     0);
    check({tag, "_daddr"}, 32'(disp_addr),   0);
    check({tag, "_ddata"}, 32'(disp_data),   0);
    check({tag, "_dvld"},  32'(disp_valid),  0);
  endtask

  initial begin
    // Reset with the write switch already high
    rst_n      = 1'b0;
    sw_wr_req  = 1'b1;
    sw_wr_addr = '0;
    sw_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("rst");
    rst_n = 1'b1;

    // Switch held high since reset: no write until it is cycled
    goto(14);
    sw_wr_req = 1'b0;
    goto(24);
    check("no_wr_held_from_reset", wr_cnt, 0);

    // Held write: exactly one write, latency 2+4+1+1 edges
    sw_wr_addr = 5'h13;
    sw_wr_data = 8'h5A;
    sw_wr_req  = 1'b1;
    ref_mem[5'h13] = 8'h5A;
    goto(44);
    sw_wr_req  = 1'b0;
    sw_wr_addr = 5'h07;
    sw_wr_data = 8'hFF;
    goto(56);
    check("held_wr_count", wr_cnt, 1);
    check("held_done_count", done_cnt, 1);
    check("held_wr_addr", wr_a, 32'h13);
    check("held_wr_data", wr_d, 32'h5A);
    check("held_wr_cycle", wr_cyc, 32);

    // Two-cycle glitch: ignored
    sw_wr_addr = 5'h02;
    sw_wr_data = 8'h77;
    sw_wr_req  = 1'b1;
    goto(58);
    sw_wr_req = 1'b0;
    goto(70);
    check("glitch_wr_count", wr_cnt, 1);
    check("glitch_done_count", done_cnt, 1);

    // Write request lands during the read entered at edge 81
    goto(75);
    sw_wr_addr = 5'h05;
    sw_wr_data = 8'hC3;
    sw_wr_req  = 1'b1;
    ref_mem[5'h05] = 8'hC3;
    goto(86);
    check("rw_disp_cycle", disp_cyc, 84);
    check("rw_disp_addr", disp_a_last, 10);
    check("rw_wr_cycle", wr_cyc, 85);
    check("rw_wr_addr", wr_a, 32'h05);
    check("rw_wr_data", wr_d, 32'hC3);
    goto(90);
    sw_wr_req = 1'b0;

    // Tick and write pending together at edge 112: write first, then read
    goto(105);
    sw_wr_addr = 5'h1E;
    sw_wr_data = 8'h3C;
    sw_wr_req  = 1'b1;
    ref_mem[5'h1E] = 8'h3C;
    goto(119);
    check("tw_wr_cycle", wr_cyc, 113);
    check("tw_wr_addr", wr_a, 32'h1E);
    check("tw_wr_data", wr_d, 32'h3C);
    check("tw_disp_cycle", disp_cyc, 118);
    check("tw_disp_addr", disp_a_last, 14);
    goto(125);
    sw_wr_req = 1'b0;

    // Scan past 0x13/0x14 and through the 31 -> 0 wrap
    goto(301);
    check("scan_13_data", d13, 32'h5A);
    check("scan_14_data", d14, 32'h00);
    check("scan_wrap_seen", seen_wrap, 1);
    check("pre_rst_disp_data", disp_data, 32'hC3);

    // Reset during WAIT of the read entered at edge 305
    goto(306);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    goto(14);
    check("post_rst_first_addr", disp_a_last, 1);
    check("post_rst_first_cycle", disp_cyc, 12);

    // Running checks gathered by the recorder
    check("scan_sequence_errs", seq_bad, 0);
    check("addr_hold_errs", hist_bad, 0);
    check("read_data_errs", data_bad, 0);
    check("idle_data_nonzero", zero_bad, 0);
    check("total_writes", wr_cnt, 3);
    check("total_done", done_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Front-end controller for the 32×8 single-port lab RAM. It conditions the raw write switch into a single clean write strobe and time-multiplexes user writes with a periodic read scan, so the RAM sees exactly one access per cycle. It also registers the read-back word for the HEX display stage. It sits between the board switches and the RAM instance, replacing the ad-hoc edge detect and the free-running scan counter.

## Interface
Parameters:
- ADDR_W, 5, RAM address width (32 words)
- DATA_W, 8, RAM data width
- TICK_DIV, 25_000_000, CLOCK_50 cycles per scan-address advance (0.5 s)
- DB_CYCLES, 1_000_000, cycles the write switch must be stable to be accepted (20 ms)
- RD_LAT, 2, RAM read latency in cycles (address register + q register)

Ports:
- CLOCK_50  in  1  sole clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sw_wr_req  in  1  raw write switch (SW[9]), asynchronous
- sw_wr_addr  in  ADDR_W  raw write address switches (SW[4:0])
- sw_wr_data  in  DATA_W  raw write data switches (SW[7:0])
- ram_address  out  ADDR_W  RAM address
- ram_data  out  DATA_W  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  DATA_W  RAM read data
- disp_addr  out  ADDR_W  address of the last completed scan read
- disp_data  out  DATA_W  data of the last completed scan read, held until the next read completes
- disp_valid  out  1  one-cycle pulse when disp_addr/disp_data update
- wr_done  out  1  one-cycle pulse when a write has been issued

## Operation
- All switch inputs pass through 2-flop synchronizers.
- Debounce:
  - The synchronized sw_wr_req must hold one level for DB_CYCLES consecutive cycles before the debounced level changes.
  - Shorter glitches are ignored.
- Write request:
  - A 0→1 transition of the debounced level sets wr_pend.
  - On that same cycle, the synchronized sw_wr_addr and sw_wr_data are latched.
  - A 1→0 transition does nothing.
  - Holding the switch high produces exactly one write.
- Scan:
  - The tick counter runs 0..TICK_DIV-1.
  - On wrap, scan_addr increments modulo 2^ADDR_W (31→0) and rd_pend is set.
  - A tick that arrives while rd_pend is already set is merged; scan_addr still advances.
- FSM states: IDLE, WRITE, READ, WAIT, CAPTURE.
  - IDLE: if wr_pend go to WRITE, else if rd_pend go to READ. A write has priority when both are pending.
  - WRITE (1 cycle): ram_address = latched address, ram_data = latched data, ram_wren = 1, wr_done = 1, clear wr_pend, go to IDLE.
  - READ (1 cycle): latch rd_addr = scan_addr, clear rd_pend, drive ram_address = rd_addr with ram_wren = 0, go to WAIT.
  - WAIT: hold ram_address for RD_LAT-1 cycles, then go to CAPTURE.
  - CAPTURE: disp_data ← ram_q, disp_addr ← rd_addr, disp_valid = 1, go to IDLE.
- Requests arriving in WRITE/READ/WAIT/CAPTURE are held pending and never dropped.
- Outside WRITE: ram_wren = 0 and ram_data = 0.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE; scan_addr, tick counter, wr_pend and rd_pend are 0.
  - The debounced level is 0, so a switch already high at reset release produces no write until it is cycled.
- Reset assertion mid-operation forces ram_wren low immediately (asynchronous) and abandons any in-flight read; disp_data returns to 0.
- Write latency: 2 (sync) + DB_CYCLES (debounce) + 1 (pend) + 1 (IDLE→WRITE) cycles from the stable switch edge to ram_wren. ram_wren is high for exactly one cycle.
- Read: READ is entered at cycle t; disp_data/disp_addr update and disp_valid is high at cycle t+RD_LAT+1.
- A write pending behind an in-flight read is delayed by at most RD_LAT+1 cycles.
- First scan read after reset: address 1, issued TICK_DIV cycles after release.

## Structure
- Package ram_ctrl_pkg holds:
  - state enum (IDLE, WRITE, READ, WAIT, CAPTURE)
  - ADDR_W and DATA_W default constants
  - the RAM latency constant shared with the RAM wrapper
- One sub-module, switch_debounce: 2-flop sync, stable counter, rising-edge pulse output; parameter DB_CYCLES.
- Data and address switch synchronizers stay in the top level.

## Test plan
Use TICK_DIV=8, DB_CYCLES=4, RD_LAT=2, with a behavioural RAM model of matching latency.
- Addr 0x13 / data 0x5A, sw_wr_req held high for 20 cycles -> exactly one ram_wren pulse with ram_address=0x13, ram_data=0x5A; wr_done pulses once.
- sw_wr_req high for 2 cycles then low -> no ram_wren, no wr_done.
- After the write above, let the scan reach address 0x13 -> disp_valid pulse with disp_addr=0x13, disp_data=0x5A. Next scan reads of 0x14 and beyond return 0x00. After 31, scan_addr wraps to 0.
- Debounced write edge lands on the cycle after READ -> read completes (disp_valid at t+3), then WRITE follows. Neither is lost and ram_address is never changed during WAIT.
- Tick and write pending together in IDLE -> WRITE first, READ on the next IDLE cycle.
- rst_n asserted during WAIT -> all outputs 0 immediately. After release, the FSM is in IDLE and the first read is address 1 after 8 cycles.
